// File: rtl/mac_array_ctrl_pkg.sv
// ============================================================================
// Module      : mac_array_ctrl_pkg
// Description : Shared types and default latencies for the mac_array job
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_array_ctrl_pkg;

    localparam int c_def_addr_w   = 10;
    localparam int c_def_len_w    = 10;
    localparam int c_def_buf_lat  = 1;
    localparam int c_def_mac_lat  = 4;
    localparam int c_def_tree_lat = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    typedef struct packed {
        logic [c_def_len_w-1:0]  len;
        logic [c_def_addr_w-1:0] base_a;
        logic [c_def_addr_w-1:0] base_b;
        logic                    sca;
    } desc_t;

    // Cycles spent in DRAIN after the last read beat.
    function automatic int drain_cycles(input int buf_lat, input int mac_lat,
                                        input int tree_lat, input bit sca);
        return buf_lat + mac_lat - 1 + (sca ? tree_lat : 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_array_ctrl_dly.sv
// ============================================================================
// Module      : mac_array_ctrl_dly
// Description : DEPTH-stage, 2-bit shift register with async active-low clear;
//               aligns {rd_en, first_beat} with operand arrival.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_array_ctrl_dly #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    logic [1:0] r_sh [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sh[i] <= 2'b00;
            end
        end else begin
            r_sh[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_sh[i] <= r_sh[i-1];
            end
        end
    end

    assign dout = r_sh[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mac_array_ctrl.sv
// ============================================================================
// Module      : mac_array_ctrl
// Description : Sequences one mac_array through accumulation jobs: operand
//               reads, new_acc/operand gating, pipeline drain, result handshake.
//               Optional perf counters enabled by MAC_ARRAY_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_array_ctrl
    import mac_array_ctrl_pkg::*;
#(
    parameter int ADDR_W   = c_def_addr_w,
    parameter int LEN_W    = c_def_len_w,
    parameter int BUF_LAT  = c_def_buf_lat,
    parameter int MAC_LAT  = c_def_mac_lat,
    parameter int TREE_LAT = c_def_tree_lat
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [LEN_W-1:0]  job_len,
    input  logic [ADDR_W-1:0] job_base_a,
    input  logic [ADDR_W-1:0] job_base_b,
    input  logic              job_sca,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic              mac_new_acc,
    output logic              mac_op_en,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_sca,
    output logic              busy
`ifdef MAC_ARRAY_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_jobs,
    output logic [31:0]       perf_busy
`endif
);

    localparam int c_drain_vec = drain_cycles(BUF_LAT, MAC_LAT, TREE_LAT, 1'b0);
    localparam int c_drain_sca = drain_cycles(BUF_LAT, MAC_LAT, TREE_LAT, 1'b1);
    localparam int c_dcnt_w    = $clog2(c_drain_sca + 1);

    state_t              r_state;
    state_t              w_next;
    logic [LEN_W-1:0]    r_beats;
    logic [c_dcnt_w-1:0] r_dcnt;
    logic [ADDR_W-1:0]   r_addr_a;
    logic [ADDR_W-1:0]   r_addr_b;
    logic                r_first;
    logic                r_sca;
    logic                w_first_beat;
    logic [1:0]          w_dly_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // r_dcnt holds the DRAIN cycles still to go, so OUT follows the cycle at 1.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (job_valid)                      w_next = ST_ISSUE;
            ST_ISSUE: if (r_beats == '0)                  w_next = ST_DRAIN;
            ST_DRAIN: if (r_dcnt == c_dcnt_w'(1))         w_next = ST_OUT;
            ST_OUT:   if (res_ready)                      w_next = ST_IDLE;
            default:                                      w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        job_ready    = (r_state == ST_IDLE);
        rd_en        = (r_state == ST_ISSUE);
        res_valid    = (r_state == ST_OUT);
        busy         = (r_state != ST_IDLE);
        w_first_beat = (r_state == ST_ISSUE) && r_first;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beats  <= '0;
            r_dcnt   <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_first  <= 1'b0;
            r_sca    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (job_valid) begin
                        r_beats  <= job_len;
                        r_addr_a <= job_base_a;
                        r_addr_b <= job_base_b;
                        r_sca    <= job_sca;
                        r_first  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_first <= 1'b0;
                    if (r_beats != '0) begin
                        r_beats  <= r_beats - LEN_W'(1);
                        r_addr_a <= r_addr_a + ADDR_W'(1);
                        r_addr_b <= r_addr_b + ADDR_W'(1);
                    end else begin
                        r_dcnt <= r_sca ? c_dcnt_w'(c_drain_sca) : c_dcnt_w'(c_drain_vec);
                    end
                end
                ST_DRAIN: begin
                    r_dcnt <= r_dcnt - c_dcnt_w'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_addr_a = r_addr_a;
    assign rd_addr_b = r_addr_b;
    assign res_sca   = r_sca;

    mac_array_ctrl_dly #(
        .DEPTH (BUF_LAT)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .din  ({rd_en, w_first_beat}),
        .dout (w_dly_out)
    );

    assign mac_op_en   = w_dly_out[1];
    assign mac_new_acc = w_dly_out[0];

`ifdef MAC_ARRAY_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_jobs <= '0;
            perf_busy <= '0;
        end else begin
            if (res_valid && res_ready && (perf_jobs != '1)) begin
                perf_jobs <= perf_jobs + 32'd1;
            end
            if (busy && (perf_busy != '1)) begin
                perf_busy <= perf_busy + 32'd1;
            end
        end
    end
`else
    // Counters are not built without MAC_ARRAY_CTRL_PERF_EN.
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_array_ctrl.sv
// ============================================================================
// Module      : tb_mac_array_ctrl
// Description : Self-checking bench for mac_array_ctrl (directed table,
//               corner sequences and randomized traffic vs. a timing model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_array_ctrl;
    import mac_array_ctrl_pkg::*;

    localparam int ADDR_W   = 10;
    localparam int LEN_W    = 10;
    localparam int BUF_LAT  = 1;
    localparam int MAC_LAT  = 4;
    localparam int TREE_LAT = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              job_valid = 1'b0;
    logic              job_ready;
    logic [LEN_W-1:0]  job_len = '0;
    logic [ADDR_W-1:0] job_base_a = '0;
    logic [ADDR_W-1:0] job_base_b = '0;
    logic              job_sca = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              mac_new_acc;
    logic              mac_op_en;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic              res_sca;
    logic              busy;
`ifdef MAC_ARRAY_CTRL_PERF_EN
    logic [31:0]       perf_jobs;
    logic [31:0]       perf_busy;
`endif

    mac_array_ctrl #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BUF_LAT(BUF_LAT),
        .MAC_LAT(MAC_LAT), .TREE_LAT(TREE_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
        .job_base_a(job_base_a), .job_base_b(job_base_b), .job_sca(job_sca),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .mac_new_acc(mac_new_acc), .mac_op_en(mac_op_en),
        .res_valid(res_valid), .res_ready(res_ready), .res_sca(res_sca),
        .busy(busy)
`ifdef MAC_ARRAY_CTRL_PERF_EN
        , .perf_jobs(perf_jobs), .perf_busy(perf_busy)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: the job in flight and when it was accepted.
    bit    m_active   = 1'b0;
    int    m_T        = 0;
    desc_t m_d;
    bit    m_last_sca = 1'b0;
    int    m_jobs     = 0;
    int    m_busy_cyc = 0;

    int                obs_rv;
    int                obs_na;
    int                obs_op;
    logic [ADDR_W-1:0] obs_last_a;
    int                acc_q[$];
    int                hs_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int lat_of(input desc_t d);
        return 1 + int'(d.len) + BUF_LAT + MAC_LAT + (d.sca ? TREE_LAT : 0);
    endfunction

    function automatic bit exp_rv();
        return m_active && ((cyc - m_T) >= lat_of(m_d));
    endfunction

    task automatic check_outputs();
        int k;
        bit e_rd, e_op, e_na;
        logic [ADDR_W-1:0] ea, eb;
        k    = cyc - m_T;
        e_rd = m_active && (k >= 1) && (k <= 1 + int'(m_d.len));
        e_op = m_active && (k >= 1 + BUF_LAT) && (k <= 1 + int'(m_d.len) + BUF_LAT);
        e_na = m_active && (k == 1 + BUF_LAT);
        chk("job_ready",   32'(job_ready),   32'(!m_active));
        chk("busy",        32'(busy),        32'(m_active));
        chk("rd_en",       32'(rd_en),       32'(e_rd));
        chk("mac_op_en",   32'(mac_op_en),   32'(e_op));
        chk("mac_new_acc", 32'(mac_new_acc), 32'(e_na));
        chk("res_valid",   32'(res_valid),   32'(exp_rv()));
        chk("res_sca",     32'(res_sca),     32'(m_active ? m_d.sca : m_last_sca));
        if (e_rd) begin
            ea = m_d.base_a + ADDR_W'(k - 1);
            eb = m_d.base_b + ADDR_W'(k - 1);
            chk("rd_addr_a", 32'(rd_addr_a), 32'(ea));
            chk("rd_addr_b", 32'(rd_addr_b), 32'(eb));
        end
        if (res_valid && obs_rv < 0) obs_rv = cyc;
        if (mac_new_acc) obs_na++;
        if (mac_op_en) obs_op++;
        if (rd_en) obs_last_a = rd_addr_a;
        if (job_valid && job_ready) acc_q.push_back(cyc);
        if (res_valid && res_ready) hs_q.push_back(cyc);
    endtask

    task automatic update_model();
        if (m_active) begin
            m_busy_cyc++;
            if (exp_rv() && res_ready) begin
                m_active   = 1'b0;
                m_last_sca = m_d.sca;
                m_jobs++;
            end
        end else if (job_valid) begin
            m_active   = 1'b1;
            m_T        = cyc;
            m_d.len    = job_len;
            m_d.base_a = job_base_a;
            m_d.base_b = job_base_b;
            m_d.sca    = job_sca;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        cyc++;
        #1;
    endtask

    task automatic run_job(input desc_t d, input int rdy_delay, output int t_acc);
        int n;
        obs_rv = -1; obs_na = 0; obs_op = 0; obs_last_a = '0;
        job_valid = 1'b1; job_len = d.len; job_base_a = d.base_a;
        job_base_b = d.base_b; job_sca = d.sca; res_ready = 1'b0;
        n = 0;
        while (!m_active && n < 50) begin cycle(); n++; end
        t_acc = m_T;
        job_valid = 1'b0;
        n = 0;
        while (m_active && n < 3000) begin
            res_ready = exp_rv() && ((cyc - (m_T + lat_of(m_d))) >= rdy_delay);
            cycle();
            n++;
        end
        chk("job_complete", 32'(m_active), 32'd0);
        res_ready = 1'b0;
    endtask

    typedef struct {
        desc_t             d;
        int                rdy_delay;
        int                exp_lat;
        logic [ADDR_W-1:0] exp_last_a;
        int                exp_ops;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int   t;
        int   n;
        desc_t dm;

        tbl[0] = '{d: '{len: 10'd3, base_a: 10'h010, base_b: 10'h020, sca: 1'b0},
                   rdy_delay: 0, exp_lat: 9,  exp_last_a: 10'h013, exp_ops: 4};
        tbl[1] = '{d: '{len: 10'd3, base_a: 10'h010, base_b: 10'h020, sca: 1'b1},
                   rdy_delay: 0, exp_lat: 14, exp_last_a: 10'h013, exp_ops: 4};
        tbl[2] = '{d: '{len: 10'd3, base_a: 10'h010, base_b: 10'h020, sca: 1'b0},
                   rdy_delay: 7, exp_lat: 9,  exp_last_a: 10'h013, exp_ops: 4};
        tbl[3] = '{d: '{len: 10'd3, base_a: 10'h3FE, base_b: 10'h100, sca: 1'b0},
                   rdy_delay: 0, exp_lat: 9,  exp_last_a: 10'h001, exp_ops: 4};
        tbl[4] = '{d: '{len: 10'd0, base_a: 10'h055, base_b: 10'h066, sca: 1'b1},
                   rdy_delay: 0, exp_lat: 11, exp_last_a: 10'h055, exp_ops: 1};

        // Reset values while held in reset
        #3;
        chk("rst_job_ready", 32'(job_ready),   32'd1);
        chk("rst_rd_en",     32'(rd_en),       32'd0);
        chk("rst_op_en",     32'(mac_op_en),   32'd0);
        chk("rst_new_acc",   32'(mac_new_acc), 32'd0);
        chk("rst_res_valid", 32'(res_valid),   32'd0);
        chk("rst_res_sca",   32'(res_sca),     32'd0);
        chk("rst_busy",      32'(busy),        32'd0);
        chk("rst_addr_a",    32'(rd_addr_a),   32'd0);
        chk("rst_addr_b",    32'(rd_addr_b),   32'd0);
        #20 rst = 1'b1;
        @(posedge clk); #1;
        cycle(); cycle();

        foreach (tbl[i]) begin
            run_job(tbl[i].d, tbl[i].rdy_delay, t);
            chk("res_latency", 32'(obs_rv - t),  32'(tbl[i].exp_lat));
            chk("last_addr_a", 32'(obs_last_a),  32'(tbl[i].exp_last_a));
            chk("new_acc_cnt", 32'(obs_na),      32'd1);
            chk("op_en_cnt",   32'(obs_op),      32'(tbl[i].exp_ops));
            cycle();
        end

        // Asynchronous reset in the middle of ISSUE
        job_valid = 1'b1; job_len = 10'd20; job_base_a = 10'h100;
        job_base_b = 10'h200; job_sca = 1'b1;
        n = 0;
        while (!m_active && n < 20) begin cycle(); n++; end
        job_valid = 1'b0;
        repeat (3) cycle();
        #2 rst = 1'b0;
        #1;
        chk("arst_rd_en",     32'(rd_en),       32'd0);
        chk("arst_op_en",     32'(mac_op_en),   32'd0);
        chk("arst_new_acc",   32'(mac_new_acc), 32'd0);
        chk("arst_res_valid", 32'(res_valid),   32'd0);
        chk("arst_busy",      32'(busy),        32'd0);
        chk("arst_res_sca",   32'(res_sca),     32'd0);
        chk("arst_addr_a",    32'(rd_addr_a),   32'd0);
        chk("arst_addr_b",    32'(rd_addr_b),   32'd0);
        m_active = 1'b0; m_last_sca = 1'b0; m_jobs = 0; m_busy_cyc = 0;
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        cycle();
        run_job(tbl[0].d, 0, t);
        chk("post_rst_latency", 32'(obs_rv - t), 32'd9);

        // Back-to-back with job_valid held high
        acc_q.delete(); hs_q.delete();
        job_valid = 1'b1; job_len = 10'd2; job_base_a = 10'h040;
        job_base_b = 10'h080; job_sca = 1'b0; res_ready = 1'b1;
        n = 0;
        while (hs_q.size() < 2 && n < 200) begin cycle(); n++; end
        job_valid = 1'b0; res_ready = 1'b0;
        chk("b2b_handshakes", 32'(hs_q.size()), 32'd2);
        chk("b2b_accepts",    32'(acc_q.size()), 32'd2);
        chk("b2b_gap", (acc_q.size() >= 2 && hs_q.size() >= 1) ? 32'(acc_q[1] - hs_q[0]) : 32'hFFFF_FFFF, 32'd1);
        cycle();

        // Maximum-length job with address wrap
        dm.len = 10'h3FF; dm.base_a = 10'h200; dm.base_b = 10'h3FF; dm.sca = 1'b1;
        run_job(dm, 2, t);
        chk("max_latency",  32'(obs_rv - t), 32'd1034);
        chk("max_last_a",   32'(obs_last_a), 32'h1FF);
        chk("max_op_cnt",   32'(obs_op),     32'd1024);
        chk("max_new_acc",  32'(obs_na),     32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            job_valid  = ($urandom_range(0, 3) != 0);
            job_len    = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom_range(0, 63))
                                                     : LEN_W'($urandom_range(0, 3));
            job_base_a = ADDR_W'($urandom);
            job_base_b = ADDR_W'($urandom);
            job_sca    = 1'($urandom_range(0, 1));
            res_ready  = 1'($urandom_range(0, 1));
            cycle();
        end
        job_valid = 1'b0; res_ready = 1'b1;
        n = 0;
        while (m_active && n < 200) begin cycle(); n++; end
        res_ready = 1'b0;
        chk("random_drained", 32'(m_active), 32'd0);
        cycle();

`ifdef MAC_ARRAY_CTRL_PERF_EN
        chk("perf_jobs", perf_jobs, 32'(m_jobs));
        chk("perf_busy", perf_busy, 32'(m_busy_cyc));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/mac_array_ctrl.md
Name: mac_array_ctrl

Overview:
- Sequences one mac_array instance through accumulation jobs.
- Accepts a job descriptor: beat count, two operand-buffer base addresses, result mode.
- Issues operand-buffer reads and drives new_acc/operand gating aligned to buffer read latency.
- Waits out the MAC and adder-tree pipeline, then presents a result-valid handshake to the writeback stage. Sits between the layer scheduler and the mac_array/operand buffers.

Parameters:
- ADDR_W, 10, operand buffer address width
- LEN_W, 10, job length field width
- BUF_LAT, 1, cycles from rd_en to operand data at mac_array inputs (>=1)
- MAC_LAT, 4, cycles from last gated operand at MAC input to final value on vec_out (>=1)
- TREE_LAT, 5, adder-tree latency vec_out -> sca_out (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- job_valid  in  1  descriptor valid
- job_ready  out  1  controller accepts descriptor
- job_len  in  LEN_W  beats minus one (0 => 1 beat, all-ones => 2^LEN_W beats)
- job_base_a  in  ADDR_W  first address, operand A buffer
- job_base_b  in  ADDR_W  first address, operand B buffer
- job_sca  in  1  1: result taken from sca_out; 0: from vec_out
- rd_en  out  1  operand buffer read strobe (both buffers)
- rd_addr_a  out  ADDR_W  read address A
- rd_addr_b  out  ADDR_W  read address B
- mac_new_acc  out  1  to mac_array new_acc
- mac_op_en  out  1  operand gate; 0 forces vec_a/vec_b to zero so accumulators hold
- res_valid  out  1  result on mac_array outputs is final
- res_ready  in  1  writeback consumed result
- res_sca  out  1  latched job_sca of current result
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; job_ready=1; rd_en, mac_new_acc, mac_op_en, res_valid, res_sca, busy = 0; addresses = 0; delay lines cleared. Reset mid-job aborts the job, nothing is replayed.
- States: IDLE, ISSUE, DRAIN, OUT.
- IDLE: job_ready=1. On job_valid & job_ready at cycle T: latch descriptor; beat counter = job_len; -> ISSUE.
- ISSUE (cycles T+1 .. T+1+job_len): rd_en=1, addresses = base + beat index, wrapping modulo 2^ADDR_W. After the last beat -> DRAIN.
- rd_en is delayed BUF_LAT cycles to form mac_op_en. mac_new_acc = delayed rd_en of the first beat only, coincident with the first mac_op_en.
- DRAIN: counter loads BUF_LAT+MAC_LAT-1, plus TREE_LAT if res_sca. At 0 -> OUT.
- Result timing: res_valid first high at T+1+job_len+BUF_LAT+MAC_LAT (+TREE_LAT if sca).
- OUT: res_valid=1, held until res_ready.
  - mac_op_en=0 throughout, so vec_out/sca_out stay stable.
  - res_ready is allowed in the same cycle res_valid rises.
  - On res_valid & res_ready -> IDLE; res_valid drops the next cycle; job_ready is high in that cycle.
- job_ready=0 outside IDLE. No job overlap, so the next new_acc never corrupts an unread result.
- Job boundaries: one-beat job (job_len=0) works identically. Max-length job: counter must not overflow (LEN_W-bit counter counting down to 0).
- res_ready asserted while res_valid=0 is ignored.

Optional Feature:
- Macro MAC_ARRAY_CTRL_PERF_EN.
- Defined: adds outputs perf_jobs[31:0] (completed result handshakes) and perf_busy[31:0] (cycles with busy=1). Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; other behaviour is identical.

Decomposition:
- Package mac_array_ctrl_pkg:
  - state enum typedef (IDLE, ISSUE, DRAIN, OUT)
  - descriptor struct typedef (len, base_a, base_b, sca)
  - default latency constants
- One sub-module: mac_array_ctrl_dly, a parameterised-depth, 2-bit-wide shift register with async active-low clear. Carries {rd_en, first_beat} to {mac_op_en, mac_new_acc}.

Test Plan (defaults BUF_LAT=1, MAC_LAT=4, TREE_LAT=5):
- Vector job: accept at T, len=3, base_a=0x10, base_b=0x20, sca=0, res_ready=1 -> rd_en T+1..T+4; addrs 0x10..0x13 / 0x20..0x23; mac_new_acc only at T+2; mac_op_en T+2..T+5; res_valid at T+9 for 1 cycle.
- Scalar job: same, sca=1 -> res_valid at T+14; res_sca=1.
- Backpressure: res_ready low 7 cycles after res_valid -> res_valid held; mac_op_en=0; job_ready=0 throughout; IDLE after handshake.
- Wrap and min length: base_a=0x3FE, len=3 -> rd_addr_a 0x3FE, 0x3FF, 0x000, 0x001. Then len=0 -> single rd_en, new_acc and op_en in the same cycle.
- Async reset: assert rst=0 mid-ISSUE, between clock edges -> all outputs 0 immediately, job_ready=1 after release. A subsequent job runs with correct timing.
- Back-to-back: job_valid held high for two jobs -> second accepted exactly one cycle after the first result handshake; never during ISSUE, DRAIN or OUT.
